// File: rtl/mem_write_checker.sv
`timescale 1ns/1ps
// mem_write_checker: watches a core's data-memory write bus and compares the
// stream of writes against a small table of expected (address, data) pairs.
// Checking ends in a sticky PASS or FAIL, with a cycle-count timeout and
// diagnostic capture of the offending write.
//
// Bus handshake: MemWrite is a valid strobe with no back-pressure. The
// checker is always ready, so DataAdr/WriteData are sampled on every rising
// clk edge where MemWrite=1, and ignored otherwise.
module mem_write_checker #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int STRICT  = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       exp_wr,
   input  logic [ADDR_W-1:0]          exp_addr,
   input  logic [DATA_W-1:0]          exp_data,
   input  logic                       start,
   input  logic                       MemWrite,
   input  logic [ADDR_W-1:0]          DataAdr,
   input  logic [DATA_W-1:0]          WriteData,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic                       fail,
   output logic                       timeout,
   output logic                       exp_full,
   output logic [$clog2(DEPTH):0]     match_count,
   output logic [$clog2(DEPTH)-1:0]   err_idx,
   output logic [ADDR_W-1:0]          err_addr,
   output logic [DATA_W-1:0]          err_data,
   output logic [1:0]                 dbg_state
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int CYC_W = $clog2(TIMEOUT) + 1;
   localparam bit W_STRICT = (STRICT != 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   // Registered state
   state_t              r_state;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_rd_ptr;
   logic [CYC_W-1:0]    r_cyc;
   logic [CNT_W-1:0]    r_match_cnt;
   logic                r_timeout;
   logic [IDX_W-1:0]    r_err_idx;
   logic [ADDR_W-1:0]   r_err_addr;
   logic [DATA_W-1:0]   r_err_data;

   // Expectation table; no reset needed since r_count bounds every read
   logic [ADDR_W-1:0]   r_tab_addr [DEPTH];
   logic [DATA_W-1:0]   r_tab_data [DEPTH];

   // Next-state values
   state_t              w_nxt_state;
   logic [CNT_W-1:0]    w_nxt_count;
   logic [CNT_W-1:0]    w_nxt_rd_ptr;
   logic [CYC_W-1:0]    w_nxt_cyc;
   logic [CNT_W-1:0]    w_nxt_match_cnt;
   logic                w_nxt_timeout;
   logic [IDX_W-1:0]    w_nxt_err_idx;
   logic [ADDR_W-1:0]   w_nxt_err_addr;
   logic [DATA_W-1:0]   w_nxt_err_data;

   // Decode helpers
   logic                w_full;
   logic                w_push;
   logic [CNT_W-1:0]    w_count_after_push;
   logic [ADDR_W-1:0]   w_cur_addr;
   logic [DATA_W-1:0]   w_cur_data;
   logic                w_addr_eq;
   logic                w_data_eq;
   logic                w_match;
   logic                w_mismatch;
   logic                w_last;
   logic                w_tmo;

   assign w_full             = (r_count == CNT_W'(DEPTH));
   assign w_push             = (r_state == ST_IDLE) && exp_wr && !w_full && !clear;
   assign w_count_after_push = r_count + {{(CNT_W-1){1'b0}}, w_push};
   assign w_cur_addr         = r_tab_addr[r_rd_ptr[IDX_W-1:0]];
   assign w_cur_data         = r_tab_data[r_rd_ptr[IDX_W-1:0]];
   assign w_addr_eq          = (DataAdr == w_cur_addr);
   assign w_data_eq          = (WriteData == w_cur_data);
   assign w_match            = MemWrite && w_addr_eq && w_data_eq;
   // Loose mode only objects to a write aimed at the expected address
   assign w_mismatch         = MemWrite && !(w_addr_eq && w_data_eq) &&
                               (W_STRICT || w_addr_eq);
   assign w_last             = ((r_rd_ptr + CNT_W'(1)) == r_count);
   assign w_tmo              = (r_cyc == CYC_W'(TIMEOUT - 1));

   // Table write port: pushes land at the current fill level
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tab_addr[r_count[IDX_W-1:0]] <= exp_addr;
         r_tab_data[r_count[IDX_W-1:0]] <= exp_data;
      end
   end

   // Next-state and next-register computation; clear outranks everything
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_count     = r_count;
      w_nxt_rd_ptr    = r_rd_ptr;
      w_nxt_cyc       = r_cyc;
      w_nxt_match_cnt = r_match_cnt;
      w_nxt_timeout   = r_timeout;
      w_nxt_err_idx   = r_err_idx;
      w_nxt_err_addr  = r_err_addr;
      w_nxt_err_data  = r_err_data;

      if (clear) begin
         w_nxt_state     = ST_IDLE;
         w_nxt_count     = '0;
         w_nxt_rd_ptr    = '0;
         w_nxt_cyc       = '0;
         w_nxt_match_cnt = '0;
         w_nxt_timeout   = 1'b0;
         w_nxt_err_idx   = '0;
         w_nxt_err_addr  = '0;
         w_nxt_err_data  = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A push in the same cycle counts toward the start condition
               w_nxt_count = w_count_after_push;
               if (start && (w_count_after_push != '0)) begin
                  w_nxt_state     = ST_RUN;
                  w_nxt_rd_ptr    = '0;
                  w_nxt_cyc       = '0;
                  w_nxt_match_cnt = '0;
                  w_nxt_timeout   = 1'b0;
                  w_nxt_err_idx   = '0;
                  w_nxt_err_addr  = '0;
                  w_nxt_err_data  = '0;
               end
            end
            ST_RUN: begin
               w_nxt_cyc = r_cyc + CYC_W'(1);
               // Priority: match, then mismatch, then timeout
               if (w_match) begin
                  w_nxt_rd_ptr    = r_rd_ptr + CNT_W'(1);
                  w_nxt_match_cnt = r_match_cnt + CNT_W'(1);
                  if (w_last) begin
                     w_nxt_state = ST_PASS;
                  end
               end else if (w_mismatch) begin
                  w_nxt_state    = ST_FAIL;
                  w_nxt_err_idx  = r_rd_ptr[IDX_W-1:0];
                  w_nxt_err_addr = DataAdr;
                  w_nxt_err_data = WriteData;
               end else if (w_tmo) begin
                  w_nxt_state   = ST_FAIL;
                  w_nxt_timeout = 1'b1;
                  w_nxt_err_idx = r_rd_ptr[IDX_W-1:0];
               end
            end
            ST_PASS: begin
               w_nxt_state = ST_PASS;
            end
            ST_FAIL: begin
               w_nxt_state = ST_FAIL;
            end
            default: begin
               w_nxt_state = ST_IDLE;
            end
         endcase
      end
   end

   // State register with asynchronous reset to an empty, idle checker
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_rd_ptr    <= '0;
         r_cyc       <= '0;
         r_match_cnt <= '0;
         r_timeout   <= 1'b0;
         r_err_idx   <= '0;
         r_err_addr  <= '0;
         r_err_data  <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_count     <= w_nxt_count;
         r_rd_ptr    <= w_nxt_rd_ptr;
         r_cyc       <= w_nxt_cyc;
         r_match_cnt <= w_nxt_match_cnt;
         r_timeout   <= w_nxt_timeout;
         r_err_idx   <= w_nxt_err_idx;
         r_err_addr  <= w_nxt_err_addr;
         r_err_data  <= w_nxt_err_data;
      end
   end

   // Status outputs are straight decodes of registered state
   assign busy        = (r_state == ST_RUN);
   assign done        = (r_state == ST_PASS) || (r_state == ST_FAIL);
   assign pass        = (r_state == ST_PASS);
   assign fail        = (r_state == ST_FAIL);
   assign timeout     = r_timeout;
   assign exp_full    = w_full;
   assign match_count = r_match_cnt;
   assign err_idx     = r_err_idx;
   assign err_addr    = r_err_addr;
   assign err_data    = r_err_data;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_write_checker.sv
`timescale 1ns/1ps
// Bench for mem_write_checker: a strict and a loose instance share one
// stimulus stream; directed scenarios use constant expectations and a random
// phase compares both instances every cycle against a table-driven model.
module tb_mem_write_checker;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;
   localparam int VW    = 6 + 3 + 2 + AW + DW;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_PASS = 2;
   localparam int M_FAIL = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, clear, exp_wr, start, mem_write;
   logic [AW-1:0] exp_addr, data_adr;
   logic [DW-1:0] exp_data, write_data;

   logic          s_busy, s_done, s_pass, s_fail, s_timeout, s_exp_full;
   logic [2:0]    s_match_count;
   logic [1:0]    s_err_idx, s_dbg_state;
   logic [AW-1:0] s_err_addr;
   logic [DW-1:0] s_err_data;
   logic          l_busy, l_done, l_pass, l_fail, l_timeout, l_exp_full;
   logic [2:0]    l_match_count;
   logic [1:0]    l_err_idx, l_dbg_state;
   logic [AW-1:0] l_err_addr;
   logic [DW-1:0] l_err_data;

   wire [VW-1:0] s_vec = {s_busy, s_done, s_pass, s_fail, s_timeout, s_exp_full,
                          s_match_count, s_err_idx, s_err_addr, s_err_data};
   wire [VW-1:0] l_vec = {l_busy, l_done, l_pass, l_fail, l_timeout, l_exp_full,
                          l_match_count, l_err_idx, l_err_addr, l_err_data};

   mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(1)) u_strict (
      .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr), .exp_addr(exp_addr),
      .exp_data(exp_data), .start(start), .MemWrite(mem_write), .DataAdr(data_adr),
      .WriteData(write_data), .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
      .timeout(s_timeout), .exp_full(s_exp_full), .match_count(s_match_count),
      .err_idx(s_err_idx), .err_addr(s_err_addr), .err_data(s_err_data), .dbg_state(s_dbg_state)
   );

   mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(0)) u_loose (
      .clk(clk), .reset(reset), .clear(clear), .exp_wr(exp_wr), .exp_addr(exp_addr),
      .exp_data(exp_data), .start(start), .MemWrite(mem_write), .DataAdr(data_adr),
      .WriteData(write_data), .busy(l_busy), .done(l_done), .pass(l_pass), .fail(l_fail),
      .timeout(l_timeout), .exp_full(l_exp_full), .match_count(l_match_count),
      .err_idx(l_err_idx), .err_addr(l_err_addr), .err_data(l_err_data), .dbg_state(l_dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   // Table of expected writes as {addr, data}; index 0 = strict, 1 = loose
   logic [AW+DW-1:0] exp_q[$];
   int               m_st[2];
   int               m_mc[2];
   int               m_cyc[2];
   logic             m_to[2];
   int               m_eidx[2];
   logic [AW-1:0]    m_eaddr[2];
   logic [DW-1:0]    m_edata[2];

   function automatic void model_clear();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = M_IDLE; m_mc[i] = 0; m_cyc[i] = 0; m_to[i] = 1'b0;
         m_eidx[i] = 0; m_eaddr[i] = '0; m_edata[i] = '0;
      end
   endfunction

   // Applies the inputs present just before a rising edge
   function automatic void model_edge();
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      if (reset || clear) begin
         model_clear();
         return;
      end
      if (m_st[0] == M_IDLE) begin
         if (exp_wr && exp_q.size() < DEPTH) exp_q.push_back({exp_addr, exp_data});
         if (start && exp_q.size() > 0) begin
            for (int i = 0; i < 2; i++) begin
               m_st[i] = M_RUN; m_mc[i] = 0; m_cyc[i] = 0; m_to[i] = 1'b0;
               m_eidx[i] = 0; m_eaddr[i] = '0; m_edata[i] = '0;
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_st[i] == M_RUN) begin
               {ea, ed} = exp_q[m_mc[i]];
               if (mem_write && data_adr == ea && write_data == ed) begin
                  m_mc[i]++;
                  if (m_mc[i] == exp_q.size()) m_st[i] = M_PASS;
               end else if (mem_write && (i == 0 || data_adr == ea)) begin
                  m_st[i] = M_FAIL; m_eidx[i] = m_mc[i];
                  m_eaddr[i] = data_adr; m_edata[i] = write_data;
               end else if (m_cyc[i] == TMO - 1) begin
                  m_st[i] = M_FAIL; m_to[i] = 1'b1; m_eidx[i] = m_mc[i];
               end
               m_cyc[i]++;
            end
         end
      end
   endfunction

   function automatic logic [VW-1:0] model_vec(int i);
      logic [2:0] mc;
      logic [1:0] ei;
      mc = 3'(m_mc[i]);
      ei = 2'(m_eidx[i]);
      return {m_st[i] == M_RUN, m_st[i] >= M_PASS, m_st[i] == M_PASS, m_st[i] == M_FAIL,
              m_to[i], exp_q.size() == DEPTH, mc, ei, m_eaddr[i], m_edata[i]};
   endfunction

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; outputs are read on the falling edge
   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_wr = 1'b1; exp_addr = a; exp_data = d;
      tick();
      exp_wr = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      mem_write = 1'b1; data_adr = a; write_data = d;
      tick();
      mem_write = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++; if (s_vec !== '0) begin n_errors++; $display("FAIL reset_strict got %h want 0", s_vec); end
      n_checks++; if (l_vec !== '0) begin n_errors++; $display("FAIL reset_loose got %h want 0", l_vec); end
      reset = 1'b0;
   endtask

   task automatic test_single_pass();
      logic [VW-1:0] e;
      do_clear(); push(100, 7); do_start(); idle(12);
      e = {6'b100000, 3'd0, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL single_busy got %h want %h", s_vec, e); end
      bus_write(100, 7);
      e = {6'b011000, 3'd1, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL single_pass_strict got %h want %h", s_vec, e); end
      n_checks++; if (l_vec !== e) begin n_errors++; $display("FAIL single_pass_loose got %h want %h", l_vec, e); end
   endtask

   task automatic test_strict_mismatch();
      logic [VW-1:0] e;
      do_clear(); push(100, 7); do_start(); bus_write(96, 5);
      e = {6'b010100, 3'd0, 2'd0, 32'd96, 32'd5};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL strict_mismatch got %h want %h", s_vec, e); end
      e = {6'b100000, 3'd0, 2'd0, 32'd0, 32'd0};
      n_checks++; if (l_vec !== e) begin n_errors++; $display("FAIL loose_ignores_other got %h want %h", l_vec, e); end
      bus_write(100, 7);
      e = {6'b010100, 3'd0, 2'd0, 32'd96, 32'd5};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL strict_fail_sticky got %h want %h", s_vec, e); end
   endtask

   task automatic test_loose();
      logic [VW-1:0] e;
      do_clear(); push(100, 7); do_start(); bus_write(80, 3); bus_write(100, 7);
      e = {6'b011000, 3'd1, 2'd0, 32'd0, 32'd0};
      n_checks++; if (l_vec !== e) begin n_errors++; $display("FAIL loose_pass got %h want %h", l_vec, e); end
      e = {6'b010100, 3'd0, 2'd0, 32'd80, 32'd3};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL strict_other_addr got %h want %h", s_vec, e); end
      do_clear(); push(100, 7); do_start(); bus_write(100, 8);
      e = {6'b010100, 3'd0, 2'd0, 32'd100, 32'd8};
      n_checks++; if (l_vec !== e) begin n_errors++; $display("FAIL loose_bad_data got %h want %h", l_vec, e); end
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL strict_bad_data got %h want %h", s_vec, e); end
   endtask

   task automatic test_timeout();
      logic [VW-1:0] e;
      do_clear(); push(100, 7); do_start(); idle(15);
      e = {6'b100000, 3'd0, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL tmo_not_yet got %h want %h", s_vec, e); end
      idle(1);
      e = {6'b010110, 3'd0, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL tmo_strict got %h want %h", s_vec, e); end
      n_checks++; if (l_vec !== e) begin n_errors++; $display("FAIL tmo_loose got %h want %h", l_vec, e); end
      do_clear(); push(100, 7); do_start(); idle(15); bus_write(100, 7);
      e = {6'b011000, 3'd1, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL tmo_match_wins got %h want %h", s_vec, e); end
      do_clear(); push(100, 7); do_start(); idle(15); bus_write(100, 9);
      e = {6'b010100, 3'd0, 2'd0, 32'd100, 32'd9};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL tmo_mismatch_strict got %h want %h", s_vec, e); end
      n_checks++; if (l_vec !== e) begin n_errors++; $display("FAIL tmo_mismatch_loose got %h want %h", l_vec, e); end
   endtask

   task automatic test_full();
      logic [VW-1:0] e;
      do_clear();
      for (int i = 0; i < 5; i++) push(AW'(200 + 4 * i), DW'(30 + i));
      e = {6'b000001, 3'd0, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL full_flag got %h want %h", s_vec, e); end
      do_start();
      for (int i = 0; i < 4; i++) bus_write(AW'(200 + 4 * i), DW'(30 + i));
      e = {6'b011001, 3'd4, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL full_pass got %h want %h", s_vec, e); end
      do_clear();
      n_checks++; if (s_vec !== '0) begin n_errors++; $display("FAIL full_clear got %h want 0", s_vec); end
   endtask

   task automatic test_push_start();
      logic [VW-1:0] e;
      do_clear();
      exp_wr = 1'b1; exp_addr = 300; exp_data = 11; start = 1'b1;
      tick();
      exp_wr = 1'b0; start = 1'b0;
      e = {6'b100000, 3'd0, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL push_start_run got %h want %h", s_vec, e); end
      bus_write(300, 11);
      e = {6'b011000, 3'd1, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL push_start_pass got %h want %h", s_vec, e); end
   endtask

   task automatic test_reset_mid_run();
      logic [VW-1:0] e;
      do_clear();
      for (int i = 0; i < 3; i++) push(AW'(400 + 4 * i), DW'(50 + i));
      do_start(); bus_write(400, 50); bus_write(404, 51);
      e = {6'b100000, 3'd2, 2'd0, 32'd0, 32'd0};
      n_checks++; if (s_vec !== e) begin n_errors++; $display("FAIL mid_two_matches got %h want %h", s_vec, e); end
      reset = 1'b1;
      #1;
      n_checks++; if (s_vec !== '0) begin n_errors++; $display("FAIL mid_reset_async got %h want 0", s_vec); end
      tick();
      reset = 1'b0;
      do_start();
      n_checks++; if (s_vec !== '0) begin n_errors++; $display("FAIL start_empty_ignored got %h want 0", s_vec); end
   endtask

   task automatic test_random();
      int            n, sel, idx;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      for (int it = 0; it < 40; it++) begin
         do_clear();
         n = $urandom_range(1, 5);
         for (int j = 0; j < n; j++) push(AW'(32'h100 + 4 * $urandom_range(0, 7)), DW'($urandom_range(0, 15)));
         n_checks++;
         if (s_vec !== model_vec(0)) begin n_errors++; $display("FAIL rand_load it=%0d got %h want %h", it, s_vec, model_vec(0)); end
         do_start();
         for (int c = 0; c < TMO + 2; c++) begin
            idx = (m_mc[1] < exp_q.size()) ? m_mc[1] : 0;
            {ea, ed} = exp_q[idx];
            sel = $urandom_range(0, 9);
            mem_write = (sel >= 4);
            data_adr = (sel == 7 || sel == 9) ? AW'(32'h100 + 4 * $urandom_range(0, 7)) : ea;
            write_data = (sel == 8 || sel == 9) ? ed ^ DW'($urandom_range(1, 7)) : ed;
            exp_wr = ($urandom_range(0, 7) == 0); exp_addr = AW'($urandom); exp_data = DW'($urandom);
            start = ($urandom_range(0, 7) == 0);
            tick();
            mem_write = 1'b0; exp_wr = 1'b0; start = 1'b0;
            n_checks++;
            if (s_vec !== model_vec(0)) begin n_errors++; $display("FAIL rand_strict it=%0d cyc=%0d got %h want %h", it, c, s_vec, model_vec(0)); end
            n_checks++;
            if (l_vec !== model_vec(1)) begin n_errors++; $display("FAIL rand_loose it=%0d cyc=%0d got %h want %h", it, c, l_vec, model_vec(1)); end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1; clear = 1'b0; exp_wr = 1'b0; start = 1'b0; mem_write = 1'b0;
      exp_addr = '0; exp_data = '0; data_adr = '0; write_data = '0;
      model_clear();
      repeat (2) @(negedge clk);
      test_reset();
      test_single_pass();
      test_strict_mismatch();
      test_loose();
      test_timeout();
      test_full();
      test_push_start();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
